serial_cmd_proc: RTL
====================

# serial_cmd_proc

Parametrised byte-oriented command processor between the board UART (rx/tx byte handshake) and the trigger fabric. Decodes opcode-plus-argument frames, owns a bank of NREG 32-bit configuration registers, and streams snapshots of NCH histogram counters with an XOR checksum. Adds an argument-timeout abort and a saturating error counter.

## Interface
- NCH, 8, number of histogram channels (1..16)
- HW, 32, bits per histogram counter (multiple of 8, 8..32)
- NREG, 8, number of 32-bit configuration registers (1..16)
- TIMEOUT, 1000000, max idle cycles between argument bytes before abort (≥2)
- FW_VERSION, 8, byte returned by opcode 0x00
- clk  in  1  system clock, all logic on rising edge
- rstn  in  1  asynchronous, active-low reset
- rx_ready  in  1  one-cycle strobe, rx_data valid
- rx_data  in  8  received byte
- tx_busy  in  1  UART transmitter busy
- tx_start  out  1  one-cycle strobe, tx_data valid
- tx_data  out  8  byte to transmit
- histos  in  NCH*HW  channel c at bits [c*HW +: HW]
- hist_reset  out  1  one-cycle pulse after a full-dump snapshot
- cfg  out  NREG*32  register r at bits [r*32 +: 32]
- cfg_wstb  out  NREG  one-cycle pulse on bit r when register r written

## Operation
- States: IDLE, ARGS, EXEC, TX_LOAD, TX_HOLD.
- IDLE: on rx_ready latch opcode; opcode needs args -> ARGS (arg count 0), else -> EXEC.
- ARGS: each rx_ready stores byte at arg[n], n++; n reaching required count -> EXEC. Idle counter reset on every byte; reaching TIMEOUT -> IDLE, frame discarded, err_cnt++.
- Opcodes (args little-endian):
  - 0x00, 0 args: reply FW_VERSION (1 byte, no checksum).
  - 0x01, 5 args (a, v0..v3): a<NREG -> cfg[a]={v3,v2,v1,v0}, cfg_wstb[a] pulse; else no write, err_cnt++. No reply.
  - 0x02, 1 arg a: reply cfg[a] 4 bytes LSB first + checksum; a≥NREG -> 4 zero bytes + 0x00, err_cnt++.
  - 0x03, 0 args: snapshot all histos; reply NCH*HW/8 bytes, channel 0 first, LSB first, + checksum; hist_reset pulse.
  - 0x04, 1 arg k: snapshot channel k only; reply HW/8 bytes + checksum; no hist_reset; k≥NCH -> zeros + 0x00, err_cnt++.
  - 0x05, 0 args: reply err_cnt (1 byte), then err_cnt cleared.
  - Any other opcode: no reply, err_cnt++.
- err_cnt: 8 bits, saturates at 0xFF.
- Checksum: XOR of all payload bytes of that reply.
- rx_ready outside IDLE/ARGS: byte dropped, no error.

## Timing
- Reset (async, immediate): tx_start=0, tx_data=0, hist_reset=0, cfg=0, cfg_wstb=0, err_cnt=0, state IDLE.
- Last frame byte strobed in cycle T -> EXEC in T+1.
- Write: cfg value and cfg_wstb[a] visible in T+2; cfg_wstb high exactly one cycle.
- Snapshot registered on clock edge ending T+1; hist_reset high in T+2 only; counts changing from T+2 on are not in the reply.
- TX_LOAD: if tx_busy=0 assert tx_start with tx_data for one cycle -> TX_HOLD; else wait.
- TX_HOLD: one cycle, advance byte index; more bytes -> TX_LOAD, else IDLE.
- First tx_start earliest T+2; consecutive tx_start ≥2 cycles apart. UART must raise tx_busy the cycle after tx_start.
- Reset mid-frame or mid-reply: frame and remaining bytes lost, no partial state retained.
- Byte index width covers NCH*HW/8+1 ≤ 65.

## Test plan
- 0x00, tx_busy held 0 -> single tx_start in T+2, tx_data=FW_VERSION (8).
- 0x01,0x03,0x78,0x56,0x34,0x12 then 0x02,0x03 -> cfg_wstb=0x08 for one cycle, cfg[3]=0x12345678; reply 78 56 34 12 + checksum 0x08.
- NCH=2,HW=16, histos={0x0102,0x0304} (ch1,ch0), opcode 0x03 -> reply 04 03 02 01, checksum 0x04; hist_reset one cycle at T+2; histos change at T+2 not reflected.
- 0x01, 0x02 then silence TIMEOUT cycles -> back to IDLE, no cfg_wstb; then 0x05 -> reply 0x01; second 0x05 -> 0x00.
- 0x04 with k=NCH -> HW/8 zero bytes + 0x00; 300 bad opcodes then 0x05 -> 0xFF.
- rstn low during 0x03 reply with tx_busy toggling -> tx_start and hist_reset 0 immediately, cfg cleared; next 0x00 answered normally.

Source files
------------

// File: rtl/serial_cmd_proc.sv
// Byte-oriented command processor: frames from the UART rx strobe are decoded into
// config-register writes/reads, histogram snapshots and status replies sent back over tx.
module serial_cmd_proc #(
  parameter int         NCH        = 8,
  parameter int         HW         = 32,
  parameter int         NREG       = 8,
  parameter int         TIMEOUT    = 1000000,
  parameter logic [7:0] FW_VERSION = 8'h08
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                rx_ready,
  input  logic [7:0]          rx_data,
  input  logic                tx_busy,
  output logic                tx_start,
  output logic [7:0]          tx_data,
  input  logic [NCH*HW-1:0]   histos,
  output logic                hist_reset,
  output logic [NREG*32-1:0]  cfg,
  output logic [NREG-1:0]     cfg_wstb
);

  localparam int         HB     = NCH * HW;
  localparam int         PW     = (HB > 32) ? HB : 32;
  localparam int         LW     = $clog2(PW / 8 + 1);
  localparam int         TW     = $clog2(TIMEOUT + 1);
  localparam logic [7:0] NREG_B = 8'(NREG);
  localparam logic [7:0] NCH_B  = 8'(NCH);

  typedef enum logic [2:0] {IDLE, ARGS, EXEC, TX_LOAD, TX_HOLD} state_t;

  function automatic logic [2:0] arg_need(input logic [7:0] op);
    case (op)
      8'h01:        arg_need = 3'd5;
      8'h02, 8'h04: arg_need = 3'd1;
      default:      arg_need = 3'd0;
    endcase
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    sat_inc = (v == 8'hFF) ? 8'hFF : v + 8'd1;
  endfunction

  state_t             state_r;
  logic [7:0]         opcode_r;
  logic [4:0][7:0]    args_r;
  logic [2:0]         arg_cnt_r;
  logic [TW-1:0]      idle_cnt_r;
  logic [7:0]         err_cnt_r;
  logic [NREG*32-1:0] cfg_r;
  logic [NREG-1:0]    cfg_wstb_r;
  logic               hist_reset_r;
  logic               tx_start_r;
  logic [7:0]         tx_data_r;
  logic [PW-1:0]      pay_r;
  logic [LW-1:0]      left_r;
  logic               ck_r;
  logic [7:0]         csum_r;

  logic [PW-1:0]      pay_s;
  logic [LW-1:0]      len_s;
  logic               ck_s;
  logic               reply_s;
  logic               bad_s;
  logic [PW-1:0]      src_pay_s;
  logic [LW-1:0]      src_left_s;
  logic               src_ck_s;
  logic [7:0]         src_csum_s;
  logic [7:0]         byte_s;
  logic [PW-1:0]      nxt_pay_s;
  logic [LW-1:0]      nxt_left_s;
  logic               nxt_ck_s;
  logic [7:0]         nxt_csum_s;

  // Decode the latched frame into a reply payload, its length and error flag
  always_comb begin
    pay_s   = '0;
    len_s   = '0;
    ck_s    = 1'b0;
    reply_s = 1'b0;
    bad_s   = 1'b0;
    case (opcode_r)
      8'h00: begin
        pay_s[7:0] = FW_VERSION;
        len_s      = LW'(1);
        reply_s    = 1'b1;
      end
      8'h01: begin
        bad_s = (args_r[0] >= NREG_B);
      end
      8'h02: begin
        for (int r = 0; r < NREG; r++) begin
          pay_s[31:0] = pay_s[31:0] | ({32{args_r[0] == 8'(r)}} & cfg_r[r*32 +: 32]);
        end
        len_s   = LW'(4);
        ck_s    = 1'b1;
        reply_s = 1'b1;
        bad_s   = (args_r[0] >= NREG_B);
      end
      8'h03: begin
        pay_s[HB-1:0] = histos;
        len_s         = LW'(HB / 8);
        ck_s          = 1'b1;
        reply_s       = 1'b1;
      end
      8'h04: begin
        for (int c = 0; c < NCH; c++) begin
          pay_s[HW-1:0] = pay_s[HW-1:0] | ({HW{args_r[0] == 8'(c)}} & histos[c*HW +: HW]);
        end
        len_s   = LW'(HW / 8);
        ck_s    = 1'b1;
        reply_s = 1'b1;
        bad_s   = (args_r[0] >= NCH_B);
      end
      8'h05: begin
        pay_s[7:0] = err_cnt_r;
        len_s      = LW'(1);
        reply_s    = 1'b1;
      end
      default: begin
        bad_s = 1'b1;
      end
    endcase
  end

  // Next byte to send: EXEC launches straight from the fresh payload so the first byte can go out in T+2
  always_comb begin
    if (state_r == EXEC) begin
      src_pay_s  = pay_s;
      src_left_s = len_s;
      src_ck_s   = ck_s;
      src_csum_s = 8'h00;
    end else begin
      src_pay_s  = pay_r;
      src_left_s = left_r;
      src_ck_s   = ck_r;
      src_csum_s = csum_r;
    end
    if (src_left_s != '0) begin
      byte_s     = src_pay_s[7:0];
      nxt_pay_s  = src_pay_s >> 8;
      nxt_left_s = src_left_s - LW'(1);
      nxt_csum_s = src_csum_s ^ src_pay_s[7:0];
      nxt_ck_s   = src_ck_s;
    end else begin
      byte_s     = src_csum_s;
      nxt_pay_s  = src_pay_s;
      nxt_left_s = '0;
      nxt_csum_s = src_csum_s;
      nxt_ck_s   = 1'b0;
    end
  end

  // Frame FSM with register bank, error counter and transmit sequencing
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r      <= IDLE;
      opcode_r     <= 8'h00;
      args_r       <= '0;
      arg_cnt_r    <= 3'd0;
      idle_cnt_r   <= '0;
      err_cnt_r    <= 8'h00;
      cfg_r        <= '0;
      cfg_wstb_r   <= '0;
      hist_reset_r <= 1'b0;
      tx_start_r   <= 1'b0;
      tx_data_r    <= 8'h00;
      pay_r        <= '0;
      left_r       <= '0;
      ck_r         <= 1'b0;
      csum_r       <= 8'h00;
    end else begin
      tx_start_r   <= 1'b0;
      cfg_wstb_r   <= '0;
      hist_reset_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (rx_ready) begin
            opcode_r   <= rx_data;
            arg_cnt_r  <= 3'd0;
            idle_cnt_r <= '0;
            state_r    <= (arg_need(rx_data) != 3'd0) ? ARGS : EXEC;
          end
        end
        ARGS: begin
          if (rx_ready) begin
            args_r[arg_cnt_r] <= rx_data;
            arg_cnt_r         <= arg_cnt_r + 3'd1;
            idle_cnt_r        <= '0;
            if (3'(arg_cnt_r + 3'd1) == arg_need(opcode_r)) begin
              state_r <= EXEC;
            end
          end else if (idle_cnt_r == TW'(TIMEOUT - 1)) begin
            err_cnt_r <= sat_inc(err_cnt_r);
            state_r   <= IDLE;
          end else begin
            idle_cnt_r <= idle_cnt_r + TW'(1);
          end
        end
        EXEC: begin
          for (int r = 0; r < NREG; r++) begin
            if (opcode_r == 8'h01 && !bad_s && args_r[0] == 8'(r)) begin
              cfg_r[r*32 +: 32] <= {args_r[4], args_r[3], args_r[2], args_r[1]};
              cfg_wstb_r[r]     <= 1'b1;
            end
          end
          hist_reset_r <= (opcode_r == 8'h03);
          if (bad_s) begin
            err_cnt_r <= sat_inc(err_cnt_r);
          end else if (opcode_r == 8'h05) begin
            err_cnt_r <= 8'h00;
          end
          if (!reply_s) begin
            state_r <= IDLE;
          end else if (!tx_busy) begin
            tx_start_r <= 1'b1;
            tx_data_r  <= byte_s;
            pay_r      <= nxt_pay_s;
            left_r     <= nxt_left_s;
            ck_r       <= nxt_ck_s;
            csum_r     <= nxt_csum_s;
            state_r    <= TX_HOLD;
          end else begin
            pay_r   <= pay_s;
            left_r  <= len_s;
            ck_r    <= ck_s;
            csum_r  <= 8'h00;
            state_r <= TX_LOAD;
          end
        end
        TX_LOAD: begin
          if (!tx_busy) begin
            tx_start_r <= 1'b1;
            tx_data_r  <= byte_s;
            pay_r      <= nxt_pay_s;
            left_r     <= nxt_left_s;
            ck_r       <= nxt_ck_s;
            csum_r     <= nxt_csum_s;
            state_r    <= TX_HOLD;
          end
        end
        TX_HOLD: begin
          state_r <= (left_r != '0 || ck_r) ? TX_LOAD : IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign tx_start   = tx_start_r;
  assign tx_data    = tx_data_r;
  assign hist_reset = hist_reset_r;
  assign cfg        = cfg_r;
  assign cfg_wstb   = cfg_wstb_r;

endmodule
